usb_ctrl_in_pkt_buf: RTL

Single-packet IN buffer for control endpoint 0, directly downstream of the serial control endpoint. It accepts descriptor and status bytes over the control endpoint's IN request/put/done interface and packetises them, up to MAX_IN_PACKET_SIZE bytes per packet. It answers IN tokens from the protocol engine with NAK, DATA0/1 or STALL. It reports the host ACK back upstream as a one-cycle in_ep_acked pulse.

---
 rtl/usb_ep_pkg.sv | 30 +++
 rtl/usb_ep_byte_ram.sv | 25 ++
 rtl/usb_ctrl_in_pkt_buf.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/usb_ep_pkg.sv
// Shared types and helpers for the EP0 IN packet buffer.
package usb_ep_pkg;

    // Response code returned to the protocol engine for an IN token
    typedef enum logic [1:0] {
        RSP_NAK   = 2'd0,
        RSP_DATA  = 2'd1,
        RSP_STALL = 2'd2
    } rsp_e;

    // Buffer state machine encoding
    typedef enum logic [2:0] {
        ST_FILL     = 3'd0,
        ST_READY    = 3'd1,
        ST_SEND     = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_STALLED  = 3'd4
    } state_e;

    // Width of count/rd_ptr: must hold the value max_size itself
    function automatic int ptr_w(input int max_size);
        return $clog2(max_size + 1);
    endfunction

    // Address width of the byte RAM (at least one bit)
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/usb_ep_byte_ram.sv
// Byte-wide packet storage: synchronous write, asynchronous read.
module usb_ep_byte_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Store one byte per cycle; contents are not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/usb_ctrl_in_pkt_buf.sv
// Single-packet IN buffer for control endpoint 0: collects bytes from the
// control endpoint, answers IN tokens with NAK/DATA/STALL and reports ACKs.
module usb_ctrl_in_pkt_buf
    import usb_ep_pkg::*;
#(
    parameter int MAX_IN_PACKET_SIZE = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_ep_req,
    output logic       in_ep_grant,
    output logic       in_ep_data_free,
    input  logic       in_ep_data_put,
    input  logic [7:0] in_ep_data,
    input  logic       in_ep_data_done,
    input  logic       in_ep_stall,
    output logic       in_ep_acked,
    input  logic       setup_token,
    input  logic       in_token,
    output logic       in_pkt_rsp_valid,
    output logic [1:0] in_pkt_rsp,
    output logic       in_data_toggle,
    output logic       in_data_valid,
    output logic [7:0] in_data,
    input  logic       in_data_get,
    input  logic       in_hs_ack
);

    localparam int PTR_W = ptr_w(MAX_IN_PACKET_SIZE);
    localparam int IDX_W = idx_w(MAX_IN_PACKET_SIZE);
    localparam logic [PTR_W-1:0] MAX_C = PTR_W'(MAX_IN_PACKET_SIZE);

    state_e           state;
    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic             toggle;
    logic             wr_en;
    logic [PTR_W-1:0] count_inc;
    logic [PTR_W-1:0] rd_inc;

    // The control endpoint is the only requester, so grant mirrors request
    assign in_ep_grant     = in_ep_req;
    assign in_ep_data_free = (state == ST_FILL) && (count < MAX_C);
    assign wr_en           = in_ep_data_put && in_ep_grant && in_ep_data_free;
    assign count_inc       = count + PTR_W'(1);
    assign rd_inc          = rd_ptr + PTR_W'(1);
    assign in_data_valid   = (state == ST_SEND) && (rd_ptr < count);
    assign in_data_toggle  = toggle;

    // Addresses are truncated; an out-of-range read only happens while
    // in_data_valid is low, and writes only happen while count < MAX.
    usb_ep_byte_ram #(
        .DEPTH (MAX_IN_PACKET_SIZE),
        .AW    (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (count[IDX_W-1:0]),
        .wdata (in_ep_data),
        .raddr (rd_ptr[IDX_W-1:0]),
        .rdata (in_data)
    );

    // Buffer state machine with registered response and acked pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_FILL;
            count            <= '0;
            rd_ptr           <= '0;
            toggle           <= 1'b1;
            in_ep_acked      <= 1'b0;
            in_pkt_rsp_valid <= 1'b0;
            in_pkt_rsp       <= RSP_NAK;
        end else begin
            in_ep_acked      <= 1'b0;
            in_pkt_rsp_valid <= 1'b0;
            if (setup_token) begin
                // A new control transfer overrides everything else
                state  <= ST_FILL;
                count  <= '0;
                rd_ptr <= '0;
                toggle <= 1'b1;
            end else if (in_ep_stall) begin
                state  <= ST_STALLED;
                count  <= '0;
                rd_ptr <= '0;
            end else begin
                case (state)
                    ST_FILL: begin
                        if (wr_en) begin
                            count <= count_inc;
                        end
                        if ((wr_en && (count_inc == MAX_C)) || in_ep_data_done) begin
                            state <= ST_READY;
                        end
                        if (in_token) begin
                            in_pkt_rsp_valid <= 1'b1;
                            in_pkt_rsp       <= RSP_NAK;
                        end
                    end
                    ST_READY: begin
                        if (in_token) begin
                            in_pkt_rsp_valid <= 1'b1;
                            in_pkt_rsp       <= RSP_DATA;
                            rd_ptr           <= '0;
                            state            <= (count == '0) ? ST_WAIT_ACK : ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (in_data_valid && in_data_get) begin
                            rd_ptr <= rd_inc;
                            if (rd_inc == count) begin
                                state <= ST_WAIT_ACK;
                            end
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (in_hs_ack) begin
                            in_ep_acked <= 1'b1;
                            toggle      <= ~toggle;
                            count       <= '0;
                            rd_ptr      <= '0;
                            state       <= ST_FILL;
                        end else if (in_token) begin
                            // Host retry after a lost ACK: resend with same PID
                            in_pkt_rsp_valid <= 1'b1;
                            in_pkt_rsp       <= RSP_DATA;
                            rd_ptr           <= '0;
                            state            <= (count == '0) ? ST_WAIT_ACK : ST_SEND;
                        end
                    end
                    ST_STALLED: begin
                        if (in_token) begin
                            in_pkt_rsp_valid <= 1'b1;
                            in_pkt_rsp       <= RSP_STALL;
                        end
                    end
                    default: begin
                        state <= ST_FILL;
                    end
                endcase
            end
        end
    end

endmodule
